pgm_rom_loader: RTL and testbench
=================================

Name: pgm_rom_loader

Overview:
- Sink end of the HPS ioctl download stream.
- Accepts 16-bit words on CLK_50M and maps each word by ioctl_index into a region of the flat SDRAM word space.
- Buffers words in a small FIFO and issues req/ack write requests to the SDRAM controller.
- Holds off the HPS with ioctl_wait, and signals when the ROM image is fully committed so the PGM core can leave reset.

Parameters:
- FIFO_DEPTH, 8, FIFO entries (power of two, ≥4).
- ADDR_W, 24, SDRAM word-address width.
- WAIT_THRESH, 6, FIFO occupancy at or above which ioctl_wait asserts.

Ports:
- CLK_50M  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download window active.
- ioctl_wr  in  1  one-cycle strobe: word valid.
- ioctl_addr  in  27  byte address within the current file.
- ioctl_dout  in  16  data word.
- ioctl_index  in  8  file/region selector.
- ioctl_wait  out  1  back-pressure to HPS.
- mem_req  out  1  write request, level.
- mem_ack  in  1  one-cycle completion pulse from SDRAM controller.
- mem_addr  out  ADDR_W  word address.
- mem_data  out  16  write data.
- rom_loaded  out  1  image fully written.
- err_index  out  1  sticky: write with unmapped index seen.
- err_ovf  out  1  sticky: write dropped because FIFO full.
- word_count  out  ADDR_W  words committed in current download.

Behaviour:
- Reset: RESET is synchronous, active-high; clock is CLK_50M. All outputs are 0 on reset.
  - FIFO flushed; state IDLE.
  - An outstanding mem_req is abandoned and a late mem_ack is ignored.
  - Reset mid-download restarts cleanly; the next rising edge of ioctl_download begins a new load.
- Region map (word base + ioctl_addr[ADDR_W:1]; ioctl_addr[0] ignored):
  - index 0 → 0x000000 (68k program).
  - index 1 → 0x100000 (tiles).
  - index 2 → 0x400000 (sprites).
  - index 3 → 0xC00000 (samples/Z80).
  - Sum is truncated to ADDR_W bits.
  - Any other index: word discarded, err_index set.
- Push: ioctl_wr && ioctl_download && mapped index && !full pushes {addr, data} into the FIFO.
  - If full: word dropped, err_ovf set.
  - Push and pop in the same cycle are both honoured. Occupancy is unchanged.
- ioctl_wait: registered, = (count ≥ WAIT_THRESH) || state==DRAIN. Asserts 1 cycle after the threshold is reached.
- Memory handshake:
  - When FIFO is non-empty and no request is pending, assert mem_req with mem_addr/mem_data taken from the FIFO head.
  - mem_req, mem_addr and mem_data stay stable until the cycle mem_ack=1.
  - On that cycle: pop, word_count++, and mem_req drops the next cycle (minimum 1-cycle low gap between requests).
  - mem_ack while mem_req=0 is ignored.
- FSM:
  - IDLE → LOAD on rising edge of ioctl_download. Clears word_count, rom_loaded, err_index, err_ovf.
  - LOAD → DRAIN on falling edge of ioctl_download.
  - DRAIN → DONE when FIFO empty && mem_req=0.
  - DONE: rom_loaded=1 (level). DONE → LOAD on next rising edge of ioctl_download.
  - A rising edge of ioctl_download while in DRAIN is held until DONE, then treated as a new LOAD.
  - ioctl_wr outside LOAD is ignored.
- Edge detection uses a registered copy of ioctl_download. No extra synchroniser: same clock domain.

Decomposition:
- Package pgm_loader_pkg holds:
  - region base constants (PGM_BASE_PRG, PGM_BASE_TILE, PGM_BASE_SPR, PGM_BASE_SND);
  - index constants;
  - the state enum {IDLE, LOAD, DRAIN, DONE}.
- Sub-module pgm_loader_fifo: synchronous FIFO, FIFO_DEPTH × (ADDR_W+16).
  - Ports: push/pop, full/empty, count.
  - Pointer wrap via modulo-depth counters.

Test Plan:
- Basic load: download index 0, 4 writes at byte addr 0,2,4,6 with data 0x1111..0x4444; ack 2 cycles after each req → mem_addr 0x000000..0x000003 in order, word_count=4, rom_loaded=1 after final ack with download low.
- Region map: index 2 write at byte addr 0x10 data 0xBEEF → mem_addr 0x400008, mem_data 0xBEEF. Index 7 write → no mem_req, err_index=1.
- Back-pressure: burst 8 writes, mem_ack withheld → ioctl_wait rises the cycle after count reaches 6. A ninth write while full sets err_ovf, and only 8 requests are issued after ack resumes.
- Drain: drop ioctl_download with 3 entries queued → ioctl_wait=1, rom_loaded stays 0 until the third ack, then rom_loaded=1 and ioctl_wait=0.
- Simultaneous push/pop: FIFO count 3, ioctl_wr coincident with mem_ack → count remains 3 and data order is preserved.
- Reset mid-operation: RESET asserted while mem_req=1 with 5 queued → next cycle mem_req=0, FIFO empty, all outputs 0. A late mem_ack causes no pop and no word_count increment.

Source files
------------

// File: rtl/pgm_rom_loader_pkg.sv
// Shared constants and types for the PGM ROM loader: region bases, file
// indices and the loader state encoding.
package pgm_loader_pkg;

  localparam logic [23:0] PGM_BASE_PRG  = 24'h000000;
  localparam logic [23:0] PGM_BASE_TILE = 24'h100000;
  localparam logic [23:0] PGM_BASE_SPR  = 24'h400000;
  localparam logic [23:0] PGM_BASE_SND  = 24'hC00000;

  localparam logic [7:0] PGM_IDX_PRG  = 8'd0;
  localparam logic [7:0] PGM_IDX_TILE = 8'd1;
  localparam logic [7:0] PGM_IDX_SPR  = 8'd2;
  localparam logic [7:0] PGM_IDX_SND  = 8'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pgm_state_e;

  function automatic logic index_mapped(input logic [7:0] idx);
    return (idx <= PGM_IDX_SND);
  endfunction

  // Unmapped indices return 0; callers must gate with index_mapped().
  function automatic logic [23:0] region_base(input logic [7:0] idx);
    logic [23:0] base;
    base = 24'h000000;
    case (idx)
      PGM_IDX_PRG:  base = PGM_BASE_PRG;
      PGM_IDX_TILE: base = PGM_BASE_TILE;
      PGM_IDX_SPR:  base = PGM_BASE_SPR;
      PGM_IDX_SND:  base = PGM_BASE_SND;
      default:      base = 24'h000000;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/pgm_rom_loader_if.sv
// Bus bundles for the loader: the HPS ioctl download stream (HPS is master)
// and the SDRAM write request channel (loader is master).
interface pgm_ioctl_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  ioctl_wait
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output ioctl_wait
  );
endinterface

interface pgm_mem_if #(parameter int ADDR_W = 24);
  logic              mem_req;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;

  modport master (
    output mem_req, mem_addr, mem_data,
    input  mem_ack
  );

  modport slave (
    input  mem_req, mem_addr, mem_data,
    output mem_ack
  );
endinterface

// File: rtl/pgm_rom_loader_fifo.sv
// Small synchronous FIFO holding {word address, data} pairs between the
// ioctl stream and the SDRAM request channel. Overfull pushes and empty
// pops are ignored here; the caller reports overflow.
module pgm_loader_fifo
  import pgm_loader_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 40,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK_50M,
  input  logic             RESET,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] slot [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = slot[rd_ptr];

  // Pointer and occupancy tracking; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; not reset, since the pointers define which entries are live.
  always_ff @(posedge CLK_50M) begin
    if (do_push && !RESET) slot[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/pgm_rom_loader.sv
// Sink of the HPS ioctl download: maps each word into the SDRAM word space by
// file index, queues it, and writes it out over a req/ack channel. Reports
// when the whole image is committed so the core can leave reset.
//
// state | meaning
// IDLE  | after reset, waiting for the first download window
// LOAD  | download window open, words accepted into the FIFO
// DRAIN | window closed, flushing remaining words to SDRAM (HPS held off)
// DONE  | image fully committed, rom_loaded high
module pgm_rom_loader
  import pgm_loader_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int ADDR_W      = 24,
  parameter int WAIT_THRESH = 6
) (
  input  logic              CLK_50M,
  input  logic              RESET,
  pgm_ioctl_if.slave        ioctl,
  pgm_mem_if.master         mem,
  output logic              rom_loaded,
  output logic              err_index,
  output logic              err_ovf,
  output logic [ADDR_W-1:0] word_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = ADDR_W + 16;

  pgm_state_e        state;
  logic              dl_q;
  logic              dl_rise;
  logic              dl_fall;
  logic              rise_pend;
  logic              wr_live;
  logic              idx_ok;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] wr_addr;
  logic [ENT_W-1:0]  head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              wait_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;
  logic              unused_addr_bits;

  assign dl_rise = ioctl.ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl.ioctl_download & dl_q;
  assign wr_live = ioctl.ioctl_wr & ioctl.ioctl_download & (state == LOAD);
  assign idx_ok  = index_mapped(ioctl.ioctl_index);
  assign push    = wr_live & idx_ok & ~fifo_full;
  // An ack only counts while a request is outstanding.
  assign pop     = req_q & mem.mem_ack;
  // Byte address to word address; the sum wraps at ADDR_W bits.
  assign wr_addr = ADDR_W'(region_base(ioctl.ioctl_index)) + ioctl.ioctl_addr[ADDR_W:1];

  // Byte lane select and address bits beyond the SDRAM space are not used.
  assign unused_addr_bits = &{1'b0, ioctl.ioctl_addr[26:ADDR_W+1], ioctl.ioctl_addr[0]};

  assign ioctl.ioctl_wait = wait_q;
  assign mem.mem_req      = req_q;
  assign mem.mem_addr     = addr_q;
  assign mem.mem_data     = data_q;

  pgm_loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .CLK_50M (CLK_50M),
    .RESET   (RESET),
    .push    (push),
    .pop     (pop),
    .wr_data ({wr_addr, ioctl.ioctl_dout}),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Load sequencing, SDRAM handshake, sticky errors and all registered outputs.
  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      state      <= IDLE;
      dl_q       <= 1'b0;
      rise_pend  <= 1'b0;
      wait_q     <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rom_loaded <= 1'b0;
      err_index  <= 1'b0;
      err_ovf    <= 1'b0;
      word_count <= '0;
    end else begin
      dl_q   <= ioctl.ioctl_download;
      wait_q <= (32'(fifo_count) >= WAIT_THRESH) || (state == DRAIN);

      // Request is raised from the FIFO head and held until acked; dropping
      // it on the ack cycle guarantees a one-cycle gap before the next one.
      if (pop) begin
        req_q      <= 1'b0;
        word_count <= word_count + ADDR_W'(1);
      end else if (!req_q && !fifo_empty) begin
        req_q  <= 1'b1;
        addr_q <= head[ENT_W-1:16];
        data_q <= head[15:0];
      end

      if (wr_live && !idx_ok)             err_index <= 1'b1;
      if (wr_live && idx_ok && fifo_full) err_ovf   <= 1'b1;

      case (state)
        IDLE: begin
          if (dl_rise) begin
            state      <= LOAD;
            word_count <= '0;
            rom_loaded <= 1'b0;
            err_index  <= 1'b0;
            err_ovf    <= 1'b0;
          end
        end
        LOAD: begin
          if (dl_fall) state <= DRAIN;
        end
        DRAIN: begin
          // A new window opening mid-drain is remembered and started from DONE.
          if (dl_rise) rise_pend <= 1'b1;
          if (fifo_empty && !req_q) begin
            state      <= DONE;
            rom_loaded <= 1'b1;
          end
        end
        DONE: begin
          if (dl_rise || rise_pend) begin
            state      <= LOAD;
            rise_pend  <= 1'b0;
            word_count <= '0;
            rom_loaded <= 1'b0;
            err_index  <= 1'b0;
            err_ovf    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pgm_rom_loader.sv
// Directed bench for pgm_rom_loader: basic load, region map, back-pressure,
// drain, simultaneous push/pop and reset mid-operation.
module tb_pgm_rom_loader;

  logic        CLK_50M;
  logic        RESET;
  logic        rom_loaded;
  logic        err_index;
  logic        err_ovf;
  logic [23:0] word_count;

  logic        auto_ack;
  logic        man_ack;
  logic        ack_en;
  int          req_age;
  int          log_n;
  logic [23:0] log_addr [64];
  logic [15:0] log_data [64];

  int total;
  int bad;

  pgm_ioctl_if             ioctl_bus ();
  pgm_mem_if #(.ADDR_W(24)) mem_bus ();

  assign mem_bus.mem_ack = auto_ack | man_ack;

  pgm_rom_loader #(
    .FIFO_DEPTH  (8),
    .ADDR_W      (24),
    .WAIT_THRESH (6)
  ) dut (
    .CLK_50M    (CLK_50M),
    .RESET      (RESET),
    .ioctl      (ioctl_bus),
    .mem        (mem_bus),
    .rom_loaded (rom_loaded),
    .err_index  (err_index),
    .err_ovf    (err_ovf),
    .word_count (word_count)
  );

  initial CLK_50M = 1'b0;
  always #10 CLK_50M = ~CLK_50M;

  // SDRAM responder: acks two cycles after a request is seen, logging each acked word.
  initial begin
    auto_ack = 1'b0;
    req_age  = 0;
    log_n    = 0;
    forever begin
      @(negedge CLK_50M);
      if (auto_ack) begin
        auto_ack = 1'b0;
        req_age  = 0;
      end else if (ack_en && mem_bus.mem_req) begin
        if (req_age >= 1) begin
          auto_ack = 1'b1;
          if (log_n < 64) begin
            log_addr[log_n] = mem_bus.mem_addr;
            log_data[log_n] = mem_bus.mem_data;
          end
          log_n++;
        end else begin
          req_age++;
        end
      end else begin
        req_age = 0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK_50M);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] idx, input logic [26:0] a, input logic [15:0] d);
    ioctl_bus.ioctl_index = idx;
    ioctl_bus.ioctl_addr  = a;
    ioctl_bus.ioctl_dout  = d;
    ioctl_bus.ioctl_wr    = 1'b1;
    step(1);
    ioctl_bus.ioctl_wr    = 1'b0;
  endtask

  task automatic wait_loaded(input string tag, input int budget);
    int i;
    i = 0;
    while (!rom_loaded && i < budget) begin
      step(1);
      i++;
    end
    chk(tag, 32'(rom_loaded), 32'h1);
  endtask

  task automatic chk_log(input string tag, input int k, input logic [23:0] a, input logic [15:0] d);
    if (k < 64) begin
      chk({tag, "_addr"}, 32'(log_addr[k]), 32'(a));
      chk({tag, "_data"}, 32'(log_data[k]), 32'(d));
    end else begin
      chk({tag, "_logidx"}, 32'(k), 32'd63);
    end
  endtask

  initial begin
    int n0;
    total = 0;
    bad   = 0;
    ack_en  = 1'b0;
    man_ack = 1'b0;
    RESET   = 1'b1;
    ioctl_bus.ioctl_download = 1'b0;
    ioctl_bus.ioctl_wr       = 1'b0;
    ioctl_bus.ioctl_addr     = '0;
    ioctl_bus.ioctl_dout     = '0;
    ioctl_bus.ioctl_index    = '0;
    step(3);

    chk("rst_mem_req",    32'(mem_bus.mem_req),    32'h0);
    chk("rst_wait",       32'(ioctl_bus.ioctl_wait), 32'h0);
    chk("rst_rom_loaded", 32'(rom_loaded),         32'h0);
    chk("rst_word_count", 32'(word_count),         32'h0);
    chk("rst_mem_addr",   32'(mem_bus.mem_addr),   32'h0);
    RESET = 1'b0;
    step(1);

    // Basic load: index 0, four words, auto-ack.
    ack_en = 1'b1;
    n0 = log_n;
    ioctl_bus.ioctl_download = 1'b1;
    step(2);
    wr(8'd0, 27'd0, 16'h1111);
    wr(8'd0, 27'd2, 16'h2222);
    wr(8'd0, 27'd4, 16'h3333);
    wr(8'd0, 27'd6, 16'h4444);
    ioctl_bus.ioctl_download = 1'b0;
    wait_loaded("basic_loaded", 100);
    chk("basic_nreq", 32'(log_n - n0), 32'd4);
    chk_log("basic_w0", n0 + 0, 24'h000000, 16'h1111);
    chk_log("basic_w1", n0 + 1, 24'h000001, 16'h2222);
    chk_log("basic_w2", n0 + 2, 24'h000002, 16'h3333);
    chk_log("basic_w3", n0 + 3, 24'h000003, 16'h4444);
    chk("basic_word_count", 32'(word_count), 32'd4);
    step(2);
    chk("basic_wait_low", 32'(ioctl_bus.ioctl_wait), 32'h0);

    // Region map: index 2 at byte 0x10, then unmapped index 7.
    n0 = log_n;
    ioctl_bus.ioctl_download = 1'b1;
    step(2);
    chk("region_wc_cleared", 32'(word_count), 32'd0);
    chk("region_loaded_cleared", 32'(rom_loaded), 32'h0);
    wr(8'd2, 27'h10, 16'hBEEF);
    wr(8'd7, 27'h20, 16'h1234);
    step(10);
    chk("region_nreq", 32'(log_n - n0), 32'd1);
    chk_log("region_spr", n0, 24'h400008, 16'hBEEF);
    chk("region_err_index", 32'(err_index), 32'h1);
    chk("region_err_ovf", 32'(err_ovf), 32'h0);
    ioctl_bus.ioctl_download = 1'b0;
    wait_loaded("region_loaded", 50);
    chk("region_word_count", 32'(word_count), 32'd1);

    // Back-pressure: 8 words with ack withheld, then a ninth into a full FIFO.
    ack_en = 1'b0;
    n0 = log_n;
    ioctl_bus.ioctl_download = 1'b1;
    step(2);
    chk("bp_err_index_cleared", 32'(err_index), 32'h0);
    for (int i = 0; i < 8; i++) begin
      wr(8'd1, 27'(2 * i), 16'hA000 + 16'(i));
      if (i == 5) chk("bp_wait_at_count6", 32'(ioctl_bus.ioctl_wait), 32'h0);
      if (i == 6) chk("bp_wait_after6", 32'(ioctl_bus.ioctl_wait), 32'h1);
    end
    chk("bp_full_count", 32'(dut.u_fifo.count), 32'd8);
    wr(8'd1, 27'd16, 16'hA008);
    chk("bp_err_ovf", 32'(err_ovf), 32'h1);
    chk("bp_count_after_drop", 32'(dut.u_fifo.count), 32'd8);
    chk("bp_head_addr", 32'(mem_bus.mem_addr), 32'h100000);
    chk("bp_head_data", 32'(mem_bus.mem_data), 32'hA000);
    ack_en = 1'b1;
    step(60);
    chk("bp_nreq", 32'(log_n - n0), 32'd8);
    chk_log("bp_first", n0, 24'h100000, 16'hA000);
    chk_log("bp_last", n0 + 7, 24'h100007, 16'hA007);
    chk("bp_word_count", 32'(word_count), 32'd8);
    chk("bp_wait_released", 32'(ioctl_bus.ioctl_wait), 32'h0);
    ioctl_bus.ioctl_download = 1'b0;
    wait_loaded("bp_loaded", 50);

    // Drain: close the window with 3 words queued, ack only afterwards.
    ack_en = 1'b0;
    n0 = log_n;
    ioctl_bus.ioctl_download = 1'b1;
    step(2);
    wr(8'd3, 27'd0, 16'h5550);
    wr(8'd3, 27'd2, 16'h5551);
    wr(8'd3, 27'd4, 16'h5552);
    ioctl_bus.ioctl_download = 1'b0;
    step(3);
    chk("drain_wait_high", 32'(ioctl_bus.ioctl_wait), 32'h1);
    chk("drain_not_loaded", 32'(rom_loaded), 32'h0);
    ack_en = 1'b1;
    for (int i = 0; i < 60 && log_n < n0 + 3; i++) step(1);
    chk("drain_nreq", 32'(log_n - n0), 32'd3);
    chk("drain_loaded_at_last_ack", 32'(rom_loaded), 32'h0);
    step(2);
    chk("drain_loaded", 32'(rom_loaded), 32'h1);
    chk("drain_wait_low", 32'(ioctl_bus.ioctl_wait), 32'h0);
    chk_log("drain_w2", n0 + 2, 24'hC00002, 16'h5552);
    chk("drain_word_count", 32'(word_count), 32'd3);

    // Simultaneous push/pop with three words queued.
    ack_en = 1'b0;
    ioctl_bus.ioctl_download = 1'b1;
    step(2);
    wr(8'd0, 27'h100, 16'h6660);
    wr(8'd0, 27'h102, 16'h6661);
    wr(8'd0, 27'h104, 16'h6662);
    step(2);
    chk("pp_count_before", 32'(dut.u_fifo.count), 32'd3);
    chk("pp_head_addr", 32'(mem_bus.mem_addr), 32'h000080);
    chk("pp_head_data", 32'(mem_bus.mem_data), 32'h6660);
    n0 = log_n;
    man_ack = 1'b1;
    wr(8'd0, 27'h106, 16'h6663);
    man_ack = 1'b0;
    chk("pp_count_same", 32'(dut.u_fifo.count), 32'd3);
    ack_en = 1'b1;
    step(40);
    chk("pp_nreq", 32'(log_n - n0), 32'd3);
    chk_log("pp_w1", n0 + 0, 24'h000081, 16'h6661);
    chk_log("pp_w2", n0 + 1, 24'h000082, 16'h6662);
    chk_log("pp_w3", n0 + 2, 24'h000083, 16'h6663);
    chk("pp_word_count", 32'(word_count), 32'd4);
    ioctl_bus.ioctl_download = 1'b0;
    wait_loaded("pp_loaded", 50);

    // Reset with a request outstanding and five words queued.
    ack_en = 1'b0;
    ioctl_bus.ioctl_download = 1'b1;
    step(2);
    for (int i = 0; i < 5; i++) wr(8'd0, 27'(2 * i), 16'h8880 + 16'(i));
    wr(8'd7, 27'd0, 16'h0000);
    step(2);
    chk("rm_req_before", 32'(mem_bus.mem_req), 32'h1);
    chk("rm_count_before", 32'(dut.u_fifo.count), 32'd5);
    chk("rm_err_index_before", 32'(err_index), 32'h1);
    RESET = 1'b1;
    ioctl_bus.ioctl_download = 1'b0;
    step(1);
    chk("rm_req", 32'(mem_bus.mem_req), 32'h0);
    chk("rm_empty", 32'(dut.u_fifo.empty), 32'h1);
    chk("rm_err_index", 32'(err_index), 32'h0);
    chk("rm_word_count", 32'(word_count), 32'd0);
    chk("rm_mem_addr", 32'(mem_bus.mem_addr), 32'h0);
    chk("rm_mem_data", 32'(mem_bus.mem_data), 32'h0);
    chk("rm_loaded", 32'(rom_loaded), 32'h0);
    RESET = 1'b0;
    man_ack = 1'b1;
    step(1);
    man_ack = 1'b0;
    step(1);
    chk("rm_late_ack_wc", 32'(word_count), 32'd0);
    chk("rm_late_ack_count", 32'(dut.u_fifo.count), 32'd0);
    chk("rm_late_ack_req", 32'(mem_bus.mem_req), 32'h0);
    n0 = log_n;
    ioctl_bus.ioctl_download = 1'b1;
    step(2);
    wr(8'd0, 27'h8, 16'h7777);
    ack_en = 1'b1;
    ioctl_bus.ioctl_download = 1'b0;
    wait_loaded("rm_reload_loaded", 50);
    chk("rm_reload_wc", 32'(word_count), 32'd1);
    chk_log("rm_reload_w", n0, 24'h000004, 16'h7777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
